// File: rtl/registro_corrimiento_universal.sv
// Universal shift register: parallel load, then shift N=min(amount,WIDTH) positions one per falling edge.
// Latency N+1 cycles from start to done; load/start are only accepted in IDLE and dropped otherwise.
module registro_corrimiento_universal #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic [SHW-1:0]   amount,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             sin,
  output logic [WIDTH-1:0] dout,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SHW-1:0]   r_cnt;
  logic             r_dir;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_data;
  logic             r_sout;

  logic [SHW-1:0]   w_amt_sat;
  logic             w_fill;
  logic [WIDTH-1:0] w_shifted;
  logic             w_shout;

  assign w_amt_sat = (amount > SHW'(WIDTH)) ? SHW'(WIDTH) : amount;

  // One-position shift of the current word using the latched direction and mode.
  always_comb begin
    w_fill    = 1'b0;
    w_shifted = r_data;
    w_shout   = r_sout;
    if (!r_dir) begin
      case (r_mode)
        2'b10:   w_fill = r_data[WIDTH-1];
        2'b11:   w_fill = sin;
        default: w_fill = 1'b0;
      endcase
      w_shifted = {r_data[WIDTH-2:0], w_fill};
      w_shout   = r_data[WIDTH-1];
    end else begin
      case (r_mode)
        2'b01:   w_fill = r_data[WIDTH-1];
        2'b10:   w_fill = r_data[0];
        2'b11:   w_fill = sin;
        default: w_fill = 1'b0;
      endcase
      w_shifted = {w_fill, r_data[WIDTH-1:1]};
      w_shout   = r_data[0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!load && start) begin
          w_state_nxt = (w_amt_sat == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (r_cnt == SHW'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Load wins over start in IDLE; both are ignored outside IDLE.
  always_ff @(negedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_dir  <= 1'b0;
      r_mode <= 2'b00;
      r_data <= '0;
      r_sout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_data <= din;
            r_sout <= 1'b0;
          end else if (start) begin
            r_cnt  <= w_amt_sat;
            r_dir  <= dir;
            r_mode <= mode;
          end
        end
        S_SHIFT: begin
          r_data <= w_shifted;
          r_sout <= w_shout;
          r_cnt  <= r_cnt - SHW'(1);
        end
        default: ;
      endcase
    end
  end

  assign dout = r_data;
  assign sout = r_sout;

endmodule

// File: tb/tb_registro_corrimiento_universal.sv
// Bench for the universal shift register: vector table plus scoreboard queue, and hand-written corner sequences.
module tb_registro_corrimiento_universal;

  localparam int WIDTH = 8;
  localparam int SHW   = $clog2(WIDTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             start;
  logic [SHW-1:0]   amount;
  logic             dir;
  logic [1:0]       mode;
  logic             sin;
  logic [WIDTH-1:0] dout;
  logic             sout;
  logic             busy;
  logic             done;

  registro_corrimiento_universal #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .din    (din),
    .start  (start),
    .amount (amount),
    .dir    (dir),
    .mode   (mode),
    .sin    (sin),
    .dout   (dout),
    .sout   (sout),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] din;
    logic [SHW-1:0]   amount;
    logic             dir;
    logic [1:0]       mode;
    logic             sin;
    logic [WIDTH-1:0] exp_dout;
    logic             exp_sout;
    int               exp_n;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] dout;
    logic             sout;
    int               n;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // DUT updates on the falling edge; drive and sample just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input bit poke_busy);
    exp_t e;
    int   nbusy;
    bit   got;
    din  = v.din;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("load_dout", 32'(dout), 32'(v.din));
    chk("load_sout", 32'(sout), 32'd0);

    amount = v.amount;
    dir    = v.dir;
    mode   = v.mode;
    sin    = v.sin;
    start  = 1'b1;
    e.dout = v.exp_dout;
    e.sout = v.exp_sout;
    e.n    = v.exp_n;
    sb.push_back(e);
    step();
    start = 1'b0;

    nbusy = 0;
    got   = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (done) begin
        got = 1'b1;
      end else begin
        if (busy) nbusy++;
        if (poke_busy && nbusy == 1) begin
          load  = 1'b1;
          start = 1'b1;
          din   = ~v.din;
        end else begin
          load  = 1'b0;
          start = 1'b0;
        end
        step();
      end
    end
    load  = 1'b0;
    start = 1'b0;

    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      chk("spurious_done", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("result_dout", 32'(dout), 32'(e.dout));
      chk("result_sout", 32'(sout), 32'(e.sout));
      chk("busy_cycles", 32'(nbusy), 32'(e.n));
      chk("busy_at_done", 32'(busy), 32'd0);
      step();
      chk("done_single", 32'(done), 32'd0);
      chk("result_hold", 32'(dout), 32'(e.dout));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int ndone;
    int nbusy;

    //          din    amt    dir   mode   sin   dout   sout  N
    vecs[0]  = '{8'hB4, 4'd3,  1'b0, 2'b00, 1'b0, 8'hA0, 1'b1, 3};
    vecs[1]  = '{8'hB4, 4'd2,  1'b1, 2'b01, 1'b0, 8'hED, 1'b0, 2};
    vecs[2]  = '{8'h81, 4'd1,  1'b0, 2'b10, 1'b0, 8'h03, 1'b1, 1};
    vecs[3]  = '{8'h81, 4'd9,  1'b1, 2'b10, 1'b0, 8'h81, 1'b1, 8};
    vecs[4]  = '{8'h00, 4'd4,  1'b1, 2'b11, 1'b1, 8'hF0, 1'b0, 4};
    vecs[5]  = '{8'h3C, 4'd0,  1'b0, 2'b00, 1'b0, 8'h3C, 1'b0, 0};
    vecs[6]  = '{8'hB4, 4'd15, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 8};
    vecs[7]  = '{8'h01, 4'd3,  1'b0, 2'b11, 1'b1, 8'h0F, 1'b0, 3};
    vecs[8]  = '{8'h80, 4'd7,  1'b1, 2'b01, 1'b0, 8'hFF, 1'b0, 7};
    vecs[9]  = '{8'h96, 4'd8,  1'b1, 2'b00, 1'b0, 8'h00, 1'b1, 8};
    vecs[10] = '{8'hC3, 4'd3,  1'b0, 2'b10, 1'b0, 8'h1E, 1'b0, 3};
    vecs[11] = '{8'hFF, 4'd2,  1'b0, 2'b11, 1'b0, 8'hFC, 1'b1, 2};

    rst = 1'b1; load = 1'b0; start = 1'b0; din = '0;
    amount = '0; dir = 1'b0; mode = 2'b00; sin = 1'b0;
    step();
    step();
    chk("reset_dout", 32'(dout), 32'd0);
    chk("reset_sout", 32'(sout), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], 1'b0);
    end

    // load/start pulsed while busy must not disturb the running shift
    run_vec(vecs[0], 1'b1);

    // load and start together: load wins, start is dropped
    din = 8'h5A; amount = 4'd3; dir = 1'b0; mode = 2'b00;
    load = 1'b1; start = 1'b1;
    step();
    load = 1'b0; start = 1'b0;
    chk("ldst_dout", 32'(dout), 32'h5A);
    chk("ldst_busy", 32'(busy), 32'd0);
    chk("ldst_done", 32'(done), 32'd0);
    ndone = 0;
    nbusy = 0;
    for (int c = 0; c < 8; c++) begin
      if (done) ndone++;
      if (busy) nbusy++;
      step();
    end
    chk("ldst_no_busy", 32'(nbusy), 32'd0);
    chk("ldst_no_done", 32'(ndone), 32'd0);
    chk("ldst_hold", 32'(dout), 32'h5A);

    // reset two cycles into a 5-position shift aborts without done
    din = 8'hF0; load = 1'b1;
    step();
    load = 1'b0;
    amount = 4'd5; dir = 1'b0; mode = 2'b00; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_sout", 32'(sout), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_dout", 32'(dout), 32'd0);
    chk("midrst_sout", 32'(sout), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) ndone++;
      step();
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/registro_corrimiento_universal.md
# registro_corrimiento_universal

Parametrised multi-cycle universal shift register for the processor datapath. It supersedes the fixed left-only and right-only shift registers with one block. The block parallel-loads a word, then on a `start` request shifts it a programmable number of positions, one position per clock. Direction and fill mode (logical, arithmetic, rotate, serial) are selected per operation, and completion is reported with a busy/done handshake. It serves the shift-and-add multiplier, the divider and the shift instructions.

## Interface
- `WIDTH`, 8: data word width in bits (≥ 2).
- `SHW` (localparam), $clog2(WIDTH)+1: width of `amount`.

- `clk`  in  1  processor clock; all state updates on the falling edge.
- `rst`  in  1  synchronous, active-high reset.
- `load`  in  1  parallel-load `din` into the register (accepted in IDLE only).
- `din`  in  WIDTH  parallel load data.
- `start`  in  1  begin a shift operation (accepted in IDLE only).
- `amount`  in  SHW  number of positions to shift, sampled with `start`.
- `dir`  in  1  0 = left, 1 = right; sampled with `start`.
- `mode`  in  2  00 logical, 01 arithmetic, 10 rotate, 11 serial fill from `sin`; sampled with `start`.
- `sin`  in  1  serial input bit, sampled every shift cycle in mode 11.
- `dout`  out  WIDTH  register contents.
- `sout`  out  1  last bit shifted out.
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - `load`: `dout` ← `din`, `sout` ← 0, state stays IDLE.
  - `start` (without `load`): latch `dir`, `mode` and `cnt` = min(`amount`, WIDTH).
    - `cnt` > 0: go to SHIFT.
    - `cnt` = 0: go to DONE with `dout` unchanged.
  - `load` and `start` together: load wins and `start` is dropped; no `done` is produced.
- **SHIFT**: one shift per edge, then `cnt` ← `cnt` − 1. When `cnt` was 1, go to DONE after that shift.
- **DONE**: `done` = 1 for exactly one cycle, then go to IDLE unconditionally.
- `load` and `start` are ignored in SHIFT and DONE. They are not queued.
- Shift rules for one position:
  - Left:
    - `sout` ← `dout`[WIDTH-1].
    - LSB fill: 0 for modes 00/01 (arithmetic left equals logical left), the old MSB for rotate, `sin` for mode 11.
  - Right:
    - `sout` ← `dout`[0].
    - MSB fill: 0 for logical, the old MSB for arithmetic (sign extension), the old LSB for rotate, `sin` for mode 11.
- `amount` values above WIDTH saturate to WIDTH. A rotate by WIDTH restores the original word.
- `sout` holds its value whenever no shift occurs.

## Timing
- Reset values: `dout` = 0, `sout` = 0, `busy` = 0, `done` = 0, state IDLE, `cnt` = 0.
- `rst` has priority over every other input. Reset during SHIFT or DONE aborts the operation; no `done` follows.
- `start` sampled at edge k with N = min(`amount`, WIDTH) ≥ 1:
  - `busy` = 1 from edge k to edge k+N.
  - Shifts occur at edges k+1 … k+N.
  - `done` = 1 between edges k+N and k+N+1.
  - Back in IDLE (new `start` accepted) at edge k+N+1.
- `start` with N = 0: `busy` stays 0 and `done` = 1 between edges k and k+1.
- `load` latency: `dout` is updated at the sampling edge and is visible for the following cycle.
- The final result is valid on `dout` in the same cycle that `done` = 1, and stays until the next `load` or shift.

## Test plan
- Assert `rst` mid-operation, e.g. 2 cycles into a shift of 5 → next cycle `dout` = 0x00, `sout` = 0, `busy` = 0, `done` = 0, and no later `done` pulse.
- WIDTH = 8: load 0xB4, then `start`, `amount` = 3, `dir` = 0, `mode` = 00 → `busy` for 3 cycles, `dout` = 0xA0, `sout` = 1, single `done` pulse at edge k+3.
- Load 0xB4, then `start`, `amount` = 2, `dir` = 1, `mode` = 01 → `dout` = 0xED, `sout` = 0.
- Load 0x81, rotate left by 1 → `dout` = 0x03, `sout` = 1. Load 0x81, rotate right with `amount` = 9 (saturates to 8) → `dout` = 0x81 after 8 busy cycles.
- Load 0x00, `mode` = 11, `dir` = 1, `sin` held at 1, `amount` = 4 → `dout` = 0xF0. `amount` = 0 → `busy` never rises, `done` pulses the next cycle, `dout` unchanged.
- `load` = 1 and `start` = 1 in the same cycle → `dout` = `din`, no `busy`, no `done`. Pulse `load` and `start` while `busy` → both ignored and the result is unchanged.
